// File: rtl/kv_add_share_arb.sv
// Round-robin arbiter sharing one EW-bit wrap-around adder between NREQ
// requesters, with a single registered result slot on a valid/ready output.
module kv_add_share_arb #(
  parameter int EW   = 32,
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*EW-1:0]   req_a,
  input  logic [NREQ*EW-1:0]   req_b,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [EW-1:0]        resp_sum
);

  logic [IDW-1:0] rr_ptr;
  logic           slot_free;
  logic           found;
  logic           accept;
  logic [IDW-1:0] win;
  logic [IDW-1:0] rr_next;
  logic [EW-1:0]  sum;
  int unsigned    win_i;

  // Winner search: first valid requester scanning upward from rr_ptr, with wrap.
  always_comb begin
    found = 1'b0;
    win_i = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      int unsigned idx;
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win_i = idx;
      end
    end
  end

  // Grant is one-hot on the winner when the slot can take a result this cycle;
  // reset is folded in so nothing is accepted while it is held.
  always_comb begin
    slot_free = !resp_valid || resp_ready;
    accept    = found && slot_free && !reset;
    req_ready = '0;
    if (accept) req_ready[win_i] = 1'b1;
    win       = IDW'(win_i);
    rr_next   = IDW'((win_i + 1) % NREQ);
    sum       = req_a[win_i*EW +: EW] + req_b[win_i*EW +: EW];
  end

  // Result slot and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_sum   <= '0;
      rr_ptr     <= '0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_id    <= win;
      resp_sum   <= sum;
      rr_ptr     <= rr_next;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_kv_add_share_arb.sv
// Directed and randomized self-checking bench for kv_add_share_arb.
module tb_kv_add_share_arb;
  localparam int EW   = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*EW-1:0] req_a;
  logic [NREQ*EW-1:0] req_b;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [EW-1:0]     resp_sum;

  int checks   = 0;
  int failures = 0;

  logic [EW-1:0] av [NREQ];
  logic [EW-1:0] bv [NREQ];

  kv_add_share_arb #(.EW(EW), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_id(resp_id), .resp_sum(resp_sum)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*EW +: EW] = av[i];
      req_b[i*EW +: EW] = bv[i];
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    resp_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    resp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin av[i] = 32'h10 * i; bv[i] = 32'h1; end
    load_ops();
    req_valid = '1;
    #2;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL rst_ready got=%b exp=0000", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_id !== 3'd0 || resp_sum !== 32'h0) begin failures++; $display("FAIL rst_data got=%0d/%h exp=0/0", resp_id, resp_sum); end
    step();
    reset = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rst_first_grant got=%b exp=0001", req_ready); end
    step();
    checks++; if (resp_valid !== 1'b1 || resp_id !== 3'd0 || resp_sum !== 32'h1) begin
      failures++; $display("FAIL rst_first_resp got=%b/%0d/%h exp=1/0/1", resp_valid, resp_id, resp_sum); end
    req_valid = '0;
    step();
  endtask

  task automatic test_carry();
    do_reset();
    av[1] = 32'hFFFF_FFFF; bv[1] = 32'h2;
    load_ops();
    resp_ready = 1'b1;
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL carry_ready got=%b exp=0010", req_ready); end
    step();
    req_valid = '0;
    checks++; if (resp_valid !== 1'b1 || resp_id !== 3'd1 || resp_sum !== 32'h1) begin
      failures++; $display("FAIL carry_resp got=%b/%0d/%h exp=1/1/1", resp_valid, resp_id, resp_sum); end
    step();
    checks++; if (resp_valid !== 1'b0 || resp_sum !== 32'h1 || resp_id !== 3'd1) begin
      failures++; $display("FAIL carry_drain got=%b/%0d/%h exp=0/1/1", resp_valid, resp_id, resp_sum); end
  endtask

  task automatic test_round_robin();
    int e;
    logic [EW-1:0] es;
    do_reset();
    av[0] = 32'h1111_0000; bv[0] = 32'h0000_0001;
    av[1] = 32'h2222_0000; bv[1] = 32'h0000_0002;
    av[2] = 32'hF000_0000; bv[2] = 32'h2000_0003;
    av[3] = 32'h4444_0000; bv[3] = 32'h0000_0004;
    load_ops();
    resp_ready = 1'b1;
    req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      e = c % NREQ;
      es = av[e] + bv[e];
      #1;
      checks++; if (req_ready !== 4'(1 << e)) begin failures++; $display("FAIL rr_grant c=%0d got=%b exp=%0d", c, req_ready, e); end
      step();
      checks++; if (resp_valid !== 1'b1 || resp_id !== 3'(e) || resp_sum !== es) begin
        failures++; $display("FAIL rr_resp c=%0d got=%b/%0d/%h exp=1/%0d/%h", c, resp_valid, resp_id, resp_sum, e, es); end
    end
    req_valid = '0;
    step();
  endtask

  task automatic test_stall();
    do_reset();
    av[0] = 32'hA; bv[0] = 32'h5;
    av[1] = 32'h100; bv[1] = 32'h23;
    av[2] = 32'h7; bv[2] = 32'h8;
    load_ops();
    resp_ready = 1'b1;
    req_valid = '1;
    step();
    resp_ready = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL stall_ready c=%0d got=%b exp=0000", c, req_ready); end
      step();
      checks++; if (resp_valid !== 1'b1 || resp_id !== 3'd0 || resp_sum !== 32'hF) begin
        failures++; $display("FAIL stall_hold c=%0d got=%b/%0d/%h exp=1/0/f", c, resp_valid, resp_id, resp_sum); end
    end
    resp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL stall_release got=%b exp=0010", req_ready); end
    step();
    checks++; if (resp_valid !== 1'b1 || resp_id !== 3'd1 || resp_sum !== 32'h123) begin
      failures++; $display("FAIL stall_b2b1 got=%b/%0d/%h exp=1/1/123", resp_valid, resp_id, resp_sum); end
    step();
    checks++; if (resp_valid !== 1'b1 || resp_id !== 3'd2 || resp_sum !== 32'hF) begin
      failures++; $display("FAIL stall_b2b2 got=%b/%0d/%h exp=1/2/f", resp_valid, resp_id, resp_sum); end
    req_valid = '0;
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    av[0] = 32'h55; bv[0] = 32'h11;
    av[2] = 32'h30; bv[2] = 32'h3;
    load_ops();
    resp_ready = 1'b1;
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL wrap_first got=%b exp=0100", req_ready); end
    step();
    checks++; if (resp_id !== 3'd2 || resp_sum !== 32'h33) begin failures++; $display("FAIL wrap_resp2 got=%0d/%h exp=2/33", resp_id, resp_sum); end
    req_valid = 4'b0101;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL wrap_grant got=%b exp=0001", req_ready); end
    step();
    checks++; if (resp_valid !== 1'b1 || resp_id !== 3'd0 || resp_sum !== 32'h66) begin
      failures++; $display("FAIL wrap_resp0 got=%b/%0d/%h exp=1/0/66", resp_valid, resp_id, resp_sum); end
    req_valid = '0;
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    av[0] = 32'h9; bv[0] = 32'h9;
    load_ops();
    resp_ready = 1'b1;
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    resp_ready = 1'b0;
    step();
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL mid_full got=%b exp=1", resp_valid); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL mid_async got=%b exp=0", resp_valid); end
    step();
    step();
    reset = 1'b0;
    resp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL mid_after c=%0d got=%b exp=0", c, resp_valid); end
    end
  endtask

  task automatic test_soak();
    logic          pend [NREQ];
    int            waits [NREQ];
    logic [IDW-1:0] qid [$];
    logic [EW-1:0]  qsum [$];
    logic [NREQ-1:0] acc;
    logic [IDW-1:0] eid;
    logic [EW-1:0]  esum;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin pend[i] = 1'b0; waits[i] = 0; end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1'b1;
          av[i] = $urandom();
          bv[i] = $urandom();
          waits[i] = 0;
        end
        req_valid[i] = pend[i];
      end
      load_ops();
      resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = req_valid & req_ready;
      checks++; if (!$onehot0(req_ready) || (req_ready & ~req_valid) != '0) begin
        failures++; $display("FAIL soak_ready c=%0d got=%b valid=%b", c, req_ready, req_valid); end
      if (resp_valid && resp_ready) begin
        checks++;
        if (qid.size() == 0) begin
          failures++; $display("FAIL soak_extra c=%0d got=%0d/%h exp=none", c, resp_id, resp_sum);
        end else begin
          eid = qid.pop_front();
          esum = qsum.pop_front();
          if (resp_id !== eid || resp_sum !== esum) begin
            failures++; $display("FAIL soak_resp c=%0d got=%0d/%h exp=%0d/%h", c, resp_id, resp_sum, eid, esum); end
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          qid.push_back(IDW'(i));
          qsum.push_back(av[i] + bv[i]);
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i] && !acc[i] && acc != '0) begin
          waits[i]++;
          checks++; if (waits[i] > NREQ - 1) begin failures++; $display("FAIL soak_fair c=%0d req=%0d got=%0d exp<=%0d", c, i, waits[i], NREQ - 1); end
        end
        if (acc[i]) pend[i] = 1'b0;
      end
      step();
    end
    req_valid = '0;
    resp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (resp_valid) begin
        checks++;
        if (qid.size() == 0) begin
          failures++; $display("FAIL soak_extra_tail got=%0d/%h exp=none", resp_id, resp_sum);
        end else begin
          eid = qid.pop_front();
          esum = qsum.pop_front();
          if (resp_id !== eid || resp_sum !== esum) begin
            failures++; $display("FAIL soak_tail got=%0d/%h exp=%0d/%h", resp_id, resp_sum, eid, esum); end
        end
      end
      step();
    end
    checks++; if (qid.size() != 0 || resp_valid !== 1'b0) begin
      failures++; $display("FAIL soak_lost got=%0d pending, valid=%b exp=0/0", qid.size(), resp_valid); end
  endtask

  initial begin
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    resp_ready = 1'b0;
    test_reset();
    test_carry();
    test_round_robin();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_soak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
